// File: rtl/alu_mc_pkg.sv
// alu_mc shared definitions: opcodes, status bit positions, FSM states.
// Used by alu_mc, alu_mc_iter and the testbench.
package alu_mc_pkg;

    localparam logic [7:0] OP_NOP  = 8'h00;
    localparam logic [7:0] OP_ADD  = 8'h01;
    localparam logic [7:0] OP_SUB  = 8'h02;
    localparam logic [7:0] OP_CPL  = 8'h03;
    localparam logic [7:0] OP_MUL  = 8'h04;
    localparam logic [7:0] OP_SHR  = 8'h05;
    localparam logic [7:0] OP_SHL  = 8'h06;
    localparam logic [7:0] OP_SAR  = 8'h07;
    localparam logic [7:0] OP_SAL  = 8'h08;
    localparam logic [7:0] OP_ROR  = 8'h09;
    localparam logic [7:0] OP_ROL  = 8'h0A;
    localparam logic [7:0] OP_NOT  = 8'h0B;
    localparam logic [7:0] OP_AND  = 8'h0C;
    localparam logic [7:0] OP_OR   = 8'h0D;
    localparam logic [7:0] OP_XOR  = 8'h0E;
    localparam logic [7:0] OP_NAND = 8'h0F;
    localparam logic [7:0] OP_NOR  = 8'h10;
    localparam logic [7:0] OP_XNOR = 8'h11;
    localparam logic [7:0] OP_DIV  = 8'h12;

    localparam int ST_N = 3;
    localparam int ST_Z = 2;
    localparam int ST_C = 1;
    localparam int ST_V = 0;

    localparam logic MODE_MUL = 1'b0;
    localparam logic MODE_DIV = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

endpackage

// File: rtl/alu_mc_if.sv
// alu_mc operation/result bus: request handshake (in_valid/in_ready,
// op, a, b) and result handshake (out_valid/out_ready, q0, q1, st, err).
interface alu_mc_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [7:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] q0;
    logic [WIDTH-1:0] q1;
    logic [3:0]       st;
    logic             err;

    modport master (
        output in_valid, op, a, b, out_ready,
        input  in_ready, out_valid, q0, q1, st, err
    );

    modport slave (
        input  in_valid, op, a, b, out_ready,
        output in_ready, out_valid, q0, q1, st, err
    );
endinterface

// File: rtl/alu_mc_iter.sv
// Shared iterative engine: shift-add multiply, restoring divide
// (divide only with ALU_MC_DIV_EN). Ports: clk, rst_n, start, mode,
// a, b in; done, hi, lo out. hi/lo show the value after the current
// step, so done marks the cycle in which the final result is valid.
module alu_mc_iter
    import alu_mc_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CW = $clog2(WIDTH);

    logic [CW-1:0]    cnt;
    logic             run;
    logic [WIDTH-1:0] m;
    logic [WIDTH-1:0] hi_r;
    logic [WIDTH-1:0] lo_r;
    logic [WIDTH:0]   add_s;

    // multiplier bit in lo_r[0]; the product shifts right into lo_r
    assign add_s = {1'b0, hi_r} + {1'b0, lo_r[0] ? m : '0};

`ifdef ALU_MC_DIV_EN
    logic [WIDTH:0]   rem_t;
    logic [WIDTH+1:0] dif;
    logic             unused_div;

    // dividend shifts out of lo_r's msb, quotient bits shift in at lsb
    assign rem_t      = {hi_r, lo_r[WIDTH-1]};
    assign dif        = {1'b0, rem_t} - {2'b0, m};
    assign unused_div = ^{dif[WIDTH], rem_t[WIDTH]};
`else
    logic unused_mode;
    assign unused_mode = mode;
`endif

    always_comb begin
        hi = add_s[WIDTH:1];
        lo = {add_s[0], lo_r[WIDTH-1:1]};
`ifdef ALU_MC_DIV_EN
        if (mode == MODE_DIV) begin
            if (!dif[WIDTH+1]) begin
                hi = dif[WIDTH-1:0];
                lo = {lo_r[WIDTH-2:0], 1'b1};
            end else begin
                hi = rem_t[WIDTH-1:0];
                lo = {lo_r[WIDTH-2:0], 1'b0};
            end
        end
`endif
    end

    assign done = run && (cnt == '0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            run  <= 1'b0;
            cnt  <= '0;
            m    <= '0;
            hi_r <= '0;
            lo_r <= '0;
        end else if (start) begin
            run  <= 1'b1;
            cnt  <= CW'(WIDTH - 1);
            m    <= b;
            hi_r <= '0;
            lo_r <= a;
        end else if (run) begin
            hi_r <= hi;
            lo_r <= lo;
            cnt  <= cnt - 1'b1;
            if (cnt == '0) begin
                run <= 1'b0;
            end
        end
    end
endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU: one op per handshake, registered q0/q1/st/err.
// Ports: clk, rst_n, bus (alu_mc_if.slave). Macro ALU_MC_DIV_EN adds DIV.
module alu_mc
    import alu_mc_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic      clk,
    input  logic      rst_n,
    alu_mc_if.slave   bus
);
    state_t state, nxt;

    logic             accept, multi, is_div, mode_r;
    logic             it_done;
    logic [WIDTH-1:0] it_hi, it_lo;
    logic [WIDTH-1:0] q0_r, q1_r;
    logic [3:0]       st_r;
    logic             err_r;

    logic [WIDTH-1:0] r_q0, r_q1;
    logic [3:0]       r_st, i_st;
    logic             r_err, nz_en;

    logic                as_sub, as_v;
    logic [WIDTH-1:0]    as_x, as_y, as_yy;
    logic [WIDTH:0]      as_sum;
    logic [SHW-1:0]      amt;
    logic [WIDTH:0]      sr_ext, sl_ext;
    logic signed [WIDTH:0] sa_ext;
    logic [2*WIDTH-1:0]  rr, rl;
    logic                unused_bits;

    assign bus.in_ready  = (state == IDLE) ||
                           (state == DONE && bus.out_ready);
    assign bus.out_valid = (state == DONE);
    assign bus.q0        = q0_r;
    assign bus.q1        = q1_r;
    assign bus.st        = st_r;
    assign bus.err       = err_r;

    assign accept = bus.in_valid && bus.in_ready;

`ifdef ALU_MC_DIV_EN
    assign is_div = (bus.op == OP_DIV) && (bus.b != '0);
`else
    assign is_div = 1'b0;
`endif
    assign multi = (bus.op == OP_MUL) || is_div;

    alu_mc_iter #(.WIDTH(WIDTH)) u_iter (
        .clk   (clk),
        .rst_n (rst_n),
        .start (accept && multi),
        .mode  (mode_r),
        .a     (bus.a),
        .b     (bus.b),
        .done  (it_done),
        .hi    (it_hi),
        .lo    (it_lo)
    );

    // CPL reuses the subtractor as 0 - a
    assign as_sub = (bus.op == OP_SUB) || (bus.op == OP_CPL);
    assign as_x   = (bus.op == OP_CPL) ? '0 : bus.a;
    assign as_y   = (bus.op == OP_CPL) ? bus.a : bus.b;
    assign as_yy  = as_sub ? ~as_y : as_y;
    assign as_sum = {1'b0, as_x} + {1'b0, as_yy} +
                    {{WIDTH{1'b0}}, as_sub};
    assign as_v   = (as_x[WIDTH-1] == as_yy[WIDTH-1]) &&
                    (as_sum[WIDTH-1] != as_x[WIDTH-1]);

    // one extra bit beyond the word catches the last bit shifted out
    assign amt    = bus.b[SHW-1:0];
    assign sr_ext = {bus.a, 1'b0} >> amt;
    assign sa_ext = $signed({bus.a, 1'b0}) >>> amt;
    assign sl_ext = {1'b0, bus.a} << amt;
    assign rr     = {bus.a, bus.a} >> amt;
    assign rl     = {bus.a, bus.a} << amt;
    assign unused_bits = ^{rr[2*WIDTH-1:WIDTH], rl[WIDTH-1:0]};

    always_comb begin
        r_q0  = '0;
        r_q1  = '0;
        r_st  = '0;
        r_err = 1'b0;
        nz_en = 1'b1;
        case (bus.op)
            OP_NOP: begin
                r_q0  = bus.a;
                r_q1  = bus.b;
                nz_en = 1'b0;
            end
            OP_ADD, OP_SUB, OP_CPL: begin
                r_q0       = as_sum[WIDTH-1:0];
                r_st[ST_C] = as_sum[WIDTH];
                r_st[ST_V] = as_v;
            end
            OP_SHR: begin
                r_q0       = sr_ext[WIDTH:1];
                r_st[ST_C] = sr_ext[0];
            end
            OP_SAR: begin
                r_q0       = sa_ext[WIDTH:1];
                r_st[ST_C] = sa_ext[0];
            end
            OP_SHL, OP_SAL: begin
                r_q0       = sl_ext[WIDTH-1:0];
                r_st[ST_C] = sl_ext[WIDTH];
            end
            OP_ROR: begin
                r_q0       = rr[WIDTH-1:0];
                r_st[ST_C] = (amt != '0) && rr[WIDTH-1];
            end
            OP_ROL: begin
                r_q0       = rl[2*WIDTH-1:WIDTH];
                r_st[ST_C] = (amt != '0) && rl[WIDTH];
            end
            OP_NOT:  r_q0 = ~bus.a;
            OP_AND:  r_q0 = bus.a & bus.b;
            OP_OR:   r_q0 = bus.a | bus.b;
            OP_XOR:  r_q0 = bus.a ^ bus.b;
            OP_NAND: r_q0 = ~(bus.a & bus.b);
            OP_NOR:  r_q0 = ~(bus.a | bus.b);
            OP_XNOR: r_q0 = ~(bus.a ^ bus.b);
`ifdef ALU_MC_DIV_EN
            // only reached as a single-cycle op when b is zero
            OP_DIV: begin
                r_q0       = '1;
                r_q1       = bus.a;
                r_st[ST_V] = 1'b1;
                nz_en      = 1'b0;
            end
`endif
            default: begin
                r_err = 1'b1;
                nz_en = 1'b0;
            end
        endcase
        if (nz_en) begin
            r_st[ST_N] = r_q0[WIDTH-1];
            r_st[ST_Z] = (r_q0 == '0);
        end
    end

    always_comb begin
        i_st = '0;
        if (mode_r == MODE_DIV) begin
            i_st[ST_Z] = (it_lo == '0);
        end else begin
            i_st[ST_Z] = (it_lo == '0) && (it_hi == '0);
            i_st[ST_C] = (it_hi != '0);
            i_st[ST_V] = (it_hi != '0);
        end
    end

    always_comb begin
        nxt = state;
        case (state)
            IDLE: begin
                if (accept) nxt = multi ? BUSY : DONE;
            end
            BUSY: begin
                if (it_done) nxt = DONE;
            end
            DONE: begin
                if (accept)             nxt = multi ? BUSY : DONE;
                else if (bus.out_ready) nxt = IDLE;
            end
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            mode_r <= MODE_MUL;
            q0_r   <= '0;
            q1_r   <= '0;
            st_r   <= '0;
            err_r  <= 1'b0;
        end else begin
            state <= nxt;
            if (accept && !multi) begin
                q0_r  <= r_q0;
                q1_r  <= r_q1;
                st_r  <= r_st;
                err_r <= r_err;
            end else if (accept) begin
                mode_r <= is_div ? MODE_DIV : MODE_MUL;
            end
            if (state == BUSY && it_done) begin
                q0_r  <= it_lo;
                q1_r  <= it_hi;
                st_r  <= i_st;
                err_r <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_alu_mc.sv
// Directed testbench for alu_mc at WIDTH=32.
// Follows ALU_MC_DIV_EN for the expected DIV behaviour.
module tb_alu_mc;
    import alu_mc_pkg::*;

    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_err;
    int   lat;
    bit   ok;

    alu_mc_if #(.WIDTH(32)) bus ();

    alu_mc #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // called just after a clock edge; returns edges until out_valid
    task automatic run(input logic [7:0] o, input logic [31:0] x,
                       input logic [31:0] y, output int l);
        bus.op       = o;
        bus.a        = x;
        bus.b        = y;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        l = 1;
        while (!bus.out_valid && l < 200) begin
            @(posedge clk);
            #1;
            l++;
        end
    endtask

    initial begin
        n_chk         = 0;
        n_err         = 0;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.op        = 8'h00;
        bus.a         = '0;
        bus.b         = '0;
        bus.out_ready = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        check("rst_ov",  bus.out_valid, 0);
        check("rst_q0",  bus.q0, 0);
        check("rst_st",  bus.st, 0);
        check("rst_err", bus.err, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rst_rdy", bus.in_ready, 1);

        run(OP_ADD, 32'h7FFFFFFF, 32'h1, lat);
        check("add_lat", lat, 1);
        check("add_q0",  bus.q0, 32'h80000000);
        check("add_q1",  bus.q1, 0);
        check("add_st",  bus.st, 4'b1001);

        run(OP_SUB, 32'd5, 32'd7, lat);
        check("sub_q0", bus.q0, 32'hFFFFFFFE);
        check("sub_st", bus.st, 4'b1000);

        run(OP_SHR, 32'd3, 32'd1, lat);
        check("shr_q0", bus.q0, 32'h1);
        check("shr_st", bus.st, 4'b0010);

        run(OP_SAR, 32'h80000000, 32'd4, lat);
        check("sar_q0", bus.q0, 32'hF8000000);
        check("sar_st", bus.st, 4'b1000);

        run(OP_ROL, 32'h80000001, 32'd1, lat);
        check("rol_q0", bus.q0, 32'h3);
        check("rol_st", bus.st, 4'b0010);

        run(OP_SHL, 32'h1, 32'd0, lat);
        check("shl0_st", bus.st, 4'b0000);

        // back-to-back single-cycle ops
        bus.op       = OP_XOR;
        bus.a        = 32'h0000FF00;
        bus.b        = 32'h00000F0F;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.op = OP_AND;
        bus.a  = 32'h000000F0;
        bus.b  = 32'h0000000F;
        check("b2b_ov1", bus.out_valid, 1);
        check("b2b_q1",  bus.q0, 32'h0000F00F);
        check("b2b_rd",  bus.in_ready, 1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        check("b2b_ov2", bus.out_valid, 1);
        check("b2b_q2",  bus.q0, 0);
        check("b2b_st2", bus.st, 4'b0100);

        // MUL with operands disturbed after accept
        bus.op       = OP_MUL;
        bus.a        = 32'h00010000;
        bus.b        = 32'h00010000;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.a        = 32'h12345678;
        bus.b        = 32'hFFFFFFFF;
        bus.op       = OP_ADD;
        ok  = 1'b1;
        lat = 1;
        while (!bus.out_valid && lat < 200) begin
            if (bus.in_ready) ok = 1'b0;
            @(posedge clk);
            #1;
            lat++;
        end
        check("mul_rdy", ok, 1);
        check("mul_lat", lat, 33);
        check("mul_q0",  bus.q0, 0);
        check("mul_q1",  bus.q1, 1);
        check("mul_st",  bus.st, 4'b0011);

        run(OP_DIV, 32'd100, 32'd7, lat);
`ifdef ALU_MC_DIV_EN
        check("div_lat", lat, 33);
        check("div_q0",  bus.q0, 14);
        check("div_q1",  bus.q1, 2);
        check("div_st",  bus.st, 0);
        check("div_err", bus.err, 0);
`else
        check("div_lat", lat, 1);
        check("div_err", bus.err, 1);
        check("div_q0",  bus.q0, 0);
`endif

        run(OP_DIV, 32'd9, 32'd0, lat);
        check("dz_lat", lat, 1);
`ifdef ALU_MC_DIV_EN
        check("dz_q0",  bus.q0, 32'hFFFFFFFF);
        check("dz_q1",  bus.q1, 9);
        check("dz_st",  bus.st, 4'b0001);
`else
        check("dz_err", bus.err, 1);
`endif

        // invalid opcode with result held back by the consumer
        bus.out_ready = 1'b0;
        run(8'h20, 32'hAAAA5555, 32'h1234, lat);
        check("bad_lat", lat, 1);
        check("bad_err", bus.err, 1);
        check("bad_q0",  bus.q0, 0);
        check("bad_q1",  bus.q1, 0);
        ok = 1'b1;
        repeat (5) begin
            @(posedge clk);
            #1;
            if (!bus.out_valid || bus.err !== 1'b1 ||
                bus.q0 !== '0 || bus.q1 !== '0 || bus.in_ready)
                ok = 1'b0;
        end
        check("hold", ok, 1);
        bus.out_ready = 1'b1;
        bus.op        = OP_ADD;
        bus.a         = 32'd1;
        bus.b         = 32'd2;
        bus.in_valid  = 1'b1;
        #1;
        check("hold_rdy", bus.in_ready, 1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        check("acc_ov",  bus.out_valid, 1);
        check("acc_q0",  bus.q0, 3);
        check("acc_err", bus.err, 0);

        // reset in the middle of a MUL
        bus.op       = OP_MUL;
        bus.a        = 32'hFFFFFFFF;
        bus.b        = 32'hFFFFFFFF;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("mrst_ov",  bus.out_valid, 0);
        check("mrst_q0",  bus.q0, 0);
        check("mrst_q1",  bus.q1, 0);
        check("mrst_st",  bus.st, 0);
        check("mrst_err", bus.err, 0);
        check("mrst_rdy", bus.in_ready, 1);
        run(OP_ADD, 32'd2, 32'd3, lat);
        check("post_lat", lat, 1);
        check("post_q0",  bus.q0, 5);
        check("post_q1",  bus.q1, 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_chk, n_err);
        $finish;
    end
endmodule
